fpu_op_sequencer: RTL and testbench
===================================

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 Parameter: RST_PULSE_CYCLES, default 2, cycles fpu_rst_n is held low per operation (1..15).
REQ-002 Parameter: SETTLE_CYCLES, default 3, cycles waited after first nonzero fpu_status before capture (1..15).
REQ-003 Parameter: TIMEOUT_CYCLES, default 64, maximum WAIT cycles before abort (8..255).
REQ-004 clock_100KHz  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 in_valid  in  1  operand pair offered.
REQ-007 in_ready  out  1  sequencer accepts operand pair.
REQ-008 in_op_a / in_op_b  in  32 each  operands, format [31] sign, [30:21] exponent, [20:0] mantissa.
REQ-009 fpu_rst_n  out  1  active-low reset to downstream FPU.
REQ-010 fpu_op_a / fpu_op_b  out  32 each  operands driven to FPU.
REQ-011 fpu_status  in  4  FPU status (0000 wait, 0001 exact, 0010 overflow, 0100 underflow, 1000 inexact).
REQ-012 fpu_data  in  32  FPU result.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 out_data  out  32  captured result; out_status  out  4  captured status.
REQ-016 busy  out  1  high in every state except IDLE; err_timeout  out  1  sticky abort flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, PULSE, WAIT, SETTLE, DONE.
REQ-018 IDLE: in_ready=1; in_valid&in_ready latches in_op_a/in_op_b into fpu_op_a/fpu_op_b -> LOAD.
REQ-019 LOAD: one cycle, fpu_rst_n=1, operands stable -> PULSE.
REQ-020 PULSE: fpu_rst_n=0 for exactly RST_PULSE_CYCLES cycles -> WAIT; counter cleared on entry.
REQ-021 WAIT: fpu_rst_n=1; fpu_status!=0 -> SETTLE; cycle counter increments each WAIT cycle.
REQ-022 SETTLE: exactly SETTLE_CYCLES cycles; on exit fpu_data->out_data, fpu_status->out_status, out_valid=1 -> DONE.
REQ-023 DONE: out_valid held with data/status stable until out_ready=1; that cycle out_valid clears next edge -> IDLE.
REQ-024 fpu_op_a/fpu_op_b SHALL hold from LOAD until next accepted pair; never change outside IDLE acceptance.
REQ-025 fpu_rst_n SHALL be 1 in all states except PULSE.
REQ-026 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE ignored, no pair queued.
REQ-027 out_ready while out_valid=0 SHALL have no effect.
REQ-028 Latency in_valid accept -> out_valid = 1+1+RST_PULSE_CYCLES+W+SETTLE_CYCLES cycles, W = WAIT cycles.
REQ-029 err_timeout SHALL clear only on reset.

Reset
REQ-030 reset low SHALL asynchronously force IDLE, in_ready=1, fpu_rst_n=0, fpu_op_a=fpu_op_b=0, out_valid=0, out_data=0, out_status=0, busy=0, err_timeout=0, counters 0.
REQ-031 After reset release fpu_rst_n SHALL register 1 on first edge; reset mid-operation discards in-flight operands and results.

Configuration
REQ-032 Macro FPU_SEQ_TIMEOUT_EN defined: WAIT reaching TIMEOUT_CYCLES cycles -> DONE with out_data=0, out_status=0000, out_valid=1, err_timeout=1.
REQ-033 Macro FPU_SEQ_TIMEOUT_EN undefined: no timeout counter compare; WAIT persists until fpu_status!=0; err_timeout tied 0.

Structure
REQ-034 Shared package fpu_pkg SHALL hold status enum codes, field widths (sign 1, exponent 10, mantissa 21) and exponent max 10'h3FF.
REQ-035 Single module, no sub-module; one shared down-counter for PULSE, WAIT and SETTLE.

Verification
REQ-036 A=0x40000000, B=0x40000000 accepted -> fpu_rst_n low 2 cycles, out_valid with out_data=fpu_data, out_status=0001 per model.
REQ-037 Model FPU holding fpu_status=0 for 100 cycles with macro defined -> out_valid after 64 WAIT cycles, out_status=0000, err_timeout=1.
REQ-038 out_ready low 10 cycles in DONE -> out_data/out_status unchanged, in_ready=0, second in_valid ignored.
REQ-039 reset asserted during WAIT -> same cycle IDLE, fpu_rst_n=0, out_valid=0; next operation completes normally.
REQ-040 fpu_status 1000 then 0010 one cycle later -> captured out_status=0010 (SETTLE_CYCLES=3).
REQ-041 Back-to-back: out_ready=1 and in_valid=1 continuous -> each result in order, one IDLE cycle between operations.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: status codes, operand field widths, sequencer states.
// Used by fpu_op_sequencer (optional abort-on-timeout via FPU_SEQ_TIMEOUT_EN).
package fpu_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 10;
    localparam int MANT_W = 21;
    localparam int DATA_W = SIGN_W + EXP_W + MANT_W;
    localparam int STAT_W = 4;
    localparam int CNT_W  = 8;

    localparam logic [EXP_W-1:0] EXP_MAX = 10'h3FF;

    typedef enum logic [STAT_W-1:0] {
        FPU_WAIT      = 4'b0000,
        FPU_EXACT     = 4'b0001,
        FPU_OVERFLOW  = 4'b0010,
        FPU_UNDERFLOW = 4'b0100,
        FPU_INEXACT   = 4'b1000
    } fpu_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PULSE,
        S_WAIT,
        S_SETTLE,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/fpu_op_sequencer.sv
// Drives one operand pair through a reset-pulsed FPU and captures the result.
// Define FPU_SEQ_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = 2,
    parameter int SETTLE_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic              clock_100KHz,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_op_a,
    input  logic [DATA_W-1:0] in_op_b,
    output logic              fpu_rst_n,
    output logic [DATA_W-1:0] fpu_op_a,
    output logic [DATA_W-1:0] fpu_op_b,
    input  logic [STAT_W-1:0] fpu_status,
    input  logic [DATA_W-1:0] fpu_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [STAT_W-1:0] out_status,
    output logic              busy,
    output logic              err_timeout
);

    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [STAT_W-1:0] stat_q, stat_d;
    logic              vld_q, vld_d;
    logic              rst_n_q, rst_n_d;
    logic              err_q, err_d;

    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            stat_q  <= '0;
            vld_q   <= 1'b0;
            rst_n_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            stat_q  <= stat_d;
            vld_q   <= vld_d;
            rst_n_q <= rst_n_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        stat_d  = stat_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_a_d  = in_op_a;
                    op_b_d  = in_op_b;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = PULSE_LD;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = WAIT_LD;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (fpu_status != FPU_WAIT) begin
                    cnt_d   = SETTLE_LD;
                    state_d = S_SETTLE;
                end
`ifdef FPU_SEQ_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    res_d   = '0;
                    stat_d  = FPU_WAIT;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            S_SETTLE: begin
                // Status may still refine during settle; sample on the last cycle
                if (cnt_q == '0) begin
                    res_d   = fpu_data;
                    stat_d  = fpu_status;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        vld_d   = (state_d == S_DONE);
        rst_n_d = (state_d != S_PULSE);
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign fpu_rst_n  = rst_n_q;
    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;
    assign out_valid  = vld_q;
    assign out_data   = res_q;
    assign out_status = stat_q;
`ifdef FPU_SEQ_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer with a behavioural FPU stand-in.
// Timeout behaviour is exercised when FPU_SEQ_TIMEOUT_EN is defined.
module tb_fpu_op_sequencer;

    localparam int RP = 2;
    localparam int SC = 3;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op_a, in_op_b;
    logic        fpu_rst_n;
    logic [31:0] fpu_op_a, fpu_op_b;
    logic [3:0]  fpu_status;
    logic [31:0] fpu_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_status;
    logic        busy;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fpu_op_sequencer #(
        .RST_PULSE_CYCLES(RP),
        .SETTLE_CYCLES   (SC),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clock_100KHz(clk),
        .reset       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op_a     (in_op_a),
        .in_op_b     (in_op_b),
        .fpu_rst_n   (fpu_rst_n),
        .fpu_op_a    (fpu_op_a),
        .fpu_op_b    (fpu_op_b),
        .fpu_status  (fpu_status),
        .fpu_data    (fpu_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_status  (out_status),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          d;
        logic [3:0]  st;
        logic [3:0]  st_late;
        logic [31:0] data;
        int          hold;
        logic [3:0]  exp_st;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: cycles after acceptance edge until DONE, given W wait cycles
    function automatic int model_lat(input int w);
        return 1 + RP + w + SC - 1 + 1;
    endfunction

    function automatic logic [3:0] model_status(input logic [3:0] st,
                                                input logic [3:0] late);
        return (late != 4'd0) ? late : st;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int d, input logic [3:0] st,
                          input logic [3:0] st_late,
                          input logic [31:0] data, input int hold,
                          input logic [3:0] exp_st, input bit keep_valid);
        int k;
        int first_ov;
        int rst_low;
        bit op_bad;
        bit rdy_bad;
        bit hold_bad;
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        in_op_a    = a;
        in_op_b    = b;
        in_valid   = 1'b1;
        out_ready  = keep_valid;
        fpu_status = 4'd0;
        fpu_data   = $urandom;
        step();
        k = 0;
        if (!keep_valid) in_valid = 1'b0;
        first_ov = -1;
        rst_low  = 0;
        op_bad   = 1'b0;
        rdy_bad  = 1'b0;
        while (first_ov < 0 && k < 400) begin
            if (fpu_rst_n !== 1'b1) rst_low++;
            if (fpu_op_a !== a || fpu_op_b !== b) op_bad = 1'b1;
            if (in_ready !== 1'b0 || busy !== 1'b1) rdy_bad = 1'b1;
            if (out_valid === 1'b1) begin
                first_ov = k;
            end else begin
                if (k == RP + d + 1) begin
                    fpu_status = st;
                    fpu_data   = data;
                end
                if (k == RP + d + 2 && st_late != 4'd0) fpu_status = st_late;
                step();
                k++;
            end
        end
        chk("latency", first_ov, model_lat(d + 1));
        chk("pulse_len", rst_low, RP);
        chk("ops_stable", {31'd0, op_bad}, 32'd0);
        chk("ready_busy", {31'd0, rdy_bad}, 32'd0);
        chk("out_data", out_data, data);
        chk("out_status", {28'd0, out_status}, {28'd0, exp_st});
        fpu_status = 4'd0;
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_op_a  = ~a;
            step();
            if (out_valid !== 1'b1 || out_data !== data ||
                out_status !== exp_st || in_ready !== 1'b0 ||
                fpu_op_a !== a)
                hold_bad = 1'b1;
        end
        if (hold > 0) chk("done_hold", {31'd0, hold_bad}, 32'd0);
        in_valid  = keep_valid;
        in_op_a   = a;
        out_ready = 1'b1;
        step();
        chk("release", {29'd0, out_valid, in_ready, busy}, 32'b010);
        if (!keep_valid) begin
            out_ready = 1'b0;
            step();
            chk("no_queue", {30'd0, busy, fpu_op_a == a}, 32'b01);
        end
    endtask

    vec_t vecs[4];

    initial begin
        int k;
        vecs[0] = '{32'h40000000, 32'h40000000, 0, 4'b0001, 4'b0000,
                    32'h40800000, 0, 4'b0001};
        vecs[1] = '{32'hC0000000, 32'h3F800000, 5, 4'b0010, 4'b0000,
                    32'h7FE00000, 10, 4'b0010};
        vecs[2] = '{32'h00000001, 32'h80000000, 3, 4'b1000, 4'b0010,
                    32'h12345678, 1, 4'b0010};
        vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 2, 4'b0100, 4'b0000,
                    32'h00000000, 2, 4'b0100};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op_a    = '0;
        in_op_b    = '0;
        fpu_status = '0;
        fpu_data   = '0;
        out_ready  = 1'b0;
        #12;
        chk("rst_ready_busy", {30'd0, in_ready, busy}, 32'b10);
        chk("rst_fpu_rst_n", {31'd0, fpu_rst_n}, 32'd0);
        chk("rst_ops", fpu_op_a | fpu_op_b, 32'd0);
        chk("rst_out", {out_data[30:0] | {27'd0, out_status}, out_valid},
            32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_release", {31'd0, fpu_rst_n}, 32'd1);

        for (int i = 0; i < 4; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].st,
                   vecs[i].st_late, vecs[i].data, vecs[i].hold,
                   vecs[i].exp_st, 1'b0);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b, data;
            logic [3:0] st, late;
            a    = $urandom;
            b    = $urandom;
            data = $urandom;
            st   = 4'(1 << $urandom_range(0, 3));
            late = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3))
                                              : 4'd0;
            run_op(a, b, $urandom_range(0, 20), st, late, data,
                   $urandom_range(0, 3), model_status(st, late), 1'b0);
        end

        for (int i = 0; i < 4; i++)
            run_op(32'hA0000000 + i, 32'h0B000000 + i, i, 4'b0001, 4'b0000,
                   32'h5500AA00 + i, 0, 4'b0001, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

`ifdef FPU_SEQ_TIMEOUT_EN
        in_op_a    = 32'h3FF00000;
        in_op_b    = 32'h3FF00000;
        in_valid   = 1'b1;
        fpu_status = 4'd0;
        fpu_data   = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        chk("timeout_lat", k, RP + TO + 1);
        chk("timeout_data", out_data, 32'd0);
        chk("timeout_status", {28'd0, out_status}, 32'd0);
        chk("timeout_err", {31'd0, err_timeout}, 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        run_op(32'h1, 32'h2, 1, 4'b0001, 4'b0000, 32'hCAFE0001, 0,
               4'b0001, 1'b0);
        chk("err_sticky", {31'd0, err_timeout}, 32'd1);
`else
        run_op(32'h1, 32'h2, 99, 4'b1000, 4'b0000, 32'hCAFE0001, 0,
               4'b1000, 1'b0);
        chk("no_timeout_err", {31'd0, err_timeout}, 32'd0);
`endif

        in_op_a  = 32'h11111111;
        in_op_b  = 32'h22222222;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < RP + 2; i++) step();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_state", {28'd0, in_ready, busy, out_valid, fpu_rst_n},
            32'b1000);
        chk("arst_ops", fpu_op_a | fpu_op_b, 32'd0);
        chk("arst_err", {31'd0, err_timeout}, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        chk("arst_release", {30'd0, fpu_rst_n, busy}, 32'b10);
        run_op(32'h33333333, 32'h44444444, 4, 4'b0100, 4'b0000,
               32'h0F0F0F0F, 0, 4'b0100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
